// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide with pipeline stall.
// Define MULDIV_EARLY_OUT_EN to finish trivial ops (x*0, divide by zero, signed overflow) without CALC.
module muldiv_sequencer (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [2:0]  i_Op,
  input  logic [31:0] i_Operand1,
  input  logic [31:0] i_Operand2,
  input  logic        i_Flush,
  output logic        o_Stall,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [31:0] o_Result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, m2;
  logic [63:0] acc, acc_nxt;
  logic        early;
  logic [32:0] sum, rem_sh;
  logic [31:0] diff;
  logic        ge;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  // Applies sign correction to the magnitude result and resolves the divide corner cases.
  function automatic logic [31:0] finish_op(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] raw);
    logic        s1, s2;
    logic [63:0] p;
    logic [31:0] q, r;
    if (!op[2]) begin
      s1 = (op == 3'd1 || op == 3'd2) && a[31];
      s2 = (op == 3'd1) && b[31];
      p  = (s1 ^ s2) ? -raw : raw;
      return (op == 3'd0) ? p[31:0] : p[63:32];
    end
    s1 = ~op[0] & a[31];
    s2 = ~op[0] & b[31];
    q  = (s1 ^ s2) ? -raw[31:0] : raw[31:0];
    r  = s1 ? -raw[63:32] : raw[63:32];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (~op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end
    return op[1] ? r : q;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  assign early = i_Op[2] ? (i_Operand2 == 32'd0 ||
                            (~i_Op[0] && i_Operand1 == 32'h8000_0000 && i_Operand2 == 32'hFFFF_FFFF))
                         : (i_Operand1 == 32'd0 || i_Operand2 == 32'd0);
`else
  assign early = 1'b0;
`endif

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    ge      = 1'b0;
    if (!op_q[2]) begin
      sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m2} : 33'd0);
      acc_nxt = {sum, acc[31:1]};
    end else begin
      rem_sh  = acc[63:31];
      ge      = rem_sh >= {1'b0, m2};
      diff    = rem_sh[31:0] - m2;
      acc_nxt = {ge ? diff : rem_sh[31:0], acc[30:0], ge};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      m2       <= 32'd0;
      acc      <= 64'd0;
      o_Result <= 32'd0;
    end else if (i_Flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: if (i_Start) begin
          op_q <= i_Op;
          a_q  <= i_Operand1;
          b_q  <= i_Operand2;
          cnt  <= 5'd0;
          if (early) begin
            state    <= DONE;
            o_Result <= finish_op(i_Op, i_Operand1, i_Operand2, 64'd0);
          end else begin
            state <= CALC;
            if (!i_Op[2]) begin
              acc <= {32'd0, mag(i_Operand2, i_Op == 3'd1)};
              m2  <= mag(i_Operand1, i_Op == 3'd1 || i_Op == 3'd2);
            end else begin
              acc <= {32'd0, mag(i_Operand1, ~i_Op[0])};
              m2  <= mag(i_Operand2, ~i_Op[0]);
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= DONE;
            o_Result <= finish_op(op_q, a_q, b_q, acc_nxt);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Busy  = (state != IDLE);
  assign o_Done  = (state == DONE);
  assign o_Stall = ~i_Reset & (((state == IDLE) & i_Start & ~i_Flush) | (state == CALC));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes expected result and done cycle, monitor checks on o_Done.
module tb_muldiv_sequencer;
  logic        i_Clock = 1'b0;
  logic        i_Reset, i_Start, i_Flush;
  logic [2:0]  i_Op;
  logic [31:0] i_Operand1, i_Operand2;
  logic        o_Stall, o_Busy, o_Done;
  logic [31:0] o_Result;

  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t scb[$];
  int cyc = 0, errs = 0, checks = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_sequencer dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(i_Start), .i_Op(i_Op),
    .i_Operand1(i_Operand1), .i_Operand2(i_Operand2), .i_Flush(i_Flush),
    .o_Stall(o_Stall), .o_Busy(o_Busy), .o_Done(o_Done), .o_Result(o_Result)
  );

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, p;
    logic [63:0] ua, ub, u;
    sa  = $signed({{32{a[31]}}, a});
    sbv = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin u = ua * ub; return u[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sbv; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit trivial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return (a == 0) || (b == 0);
    return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_Clock) begin
    if (o_Done) begin
      if (scb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_done: o_Done high with no op pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("result", o_Result, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    i_Start = 1'b1; i_Op = op; i_Operand1 = a; i_Operand2 = b;
    e.res = model(op, a, b);
    e.cyc = cyc + ((EARLY && trivial(op, a, b)) ? 1 : 33);
    scb.push_back(e);
    #1 chk("stall_accept", o_Stall, 1'b1);
    @(negedge i_Clock);
    i_Start = 1'b0; i_Op = 3'($urandom); i_Operand1 = $urandom; i_Operand2 = $urandom;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit flush_done, input bit poke);
    bit seen = 1'b0;
    issue(op, a, b);
    for (int k = 0; k < 40; k++) begin
      if (o_Done) begin
        chk("stall_done", o_Stall, 1'b0);
        if (flush_done) i_Flush = 1'b1;
        seen = 1'b1;
        break;
      end
      chk("stall_calc", o_Stall, 1'b1);
      i_Start = poke && (k == 3);
      @(negedge i_Clock);
    end
    if (!seen) begin
      checks++; errs++;
      $display("FAIL done_timeout: no o_Done within 40 cycles, op %0d", op);
    end
    @(negedge i_Clock);
    i_Flush = 1'b0; i_Start = 1'b0;
    chk("idle_after", o_Busy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    i_Reset = 1'b1; i_Start = 1'b1; i_Flush = 1'b0; i_Op = 3'd0;
    i_Operand1 = 32'd5; i_Operand2 = 32'd5;
    repeat (3) @(negedge i_Clock);
    chk("rst_busy", o_Busy, 1'b0);
    chk("rst_done", o_Done, 1'b0);
    chk("rst_result", o_Result, 32'd0);
    chk("rst_stall", o_Stall, 1'b0);
    i_Reset = 1'b0; i_Start = 1'b0;
    @(negedge i_Clock);

    run(3'd0, 32'd7, 32'd6, 0, 0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run(3'd4, -32'sd7, 32'd2, 0, 0);
    run(3'd6, -32'sd7, 32'd2, 0, 0);
    run(3'd5, 32'd5, 32'd0, 0, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run(3'd4, 32'hFFFF_FFF0, 32'd0, 0, 0);
    run(3'd7, 32'd9, 32'd0, 0, 0);
    run(3'd2, 32'd0, 32'd123, 0, 0);
    run(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);
    run(3'd0, 32'd12345, 32'd678, 0, 1);
    run(3'd4, 32'd100, 32'd7, 1, 0);

    // Flush ten cycles into a divide, then restart in the very next cycle.
    i_Start = 1'b1; i_Op = 3'd4; i_Operand1 = 32'd1000; i_Operand2 = 32'd3;
    @(negedge i_Clock);
    i_Start = 1'b0;
    repeat (9) @(negedge i_Clock);
    i_Flush = 1'b1;
    @(negedge i_Clock);
    i_Flush = 1'b0;
    chk("flush_idle", o_Busy, 1'b0);
    run(3'd0, 32'd3, 32'd3, 0, 0);

    i_Start = 1'b1; i_Flush = 1'b1; i_Op = 3'd0; i_Operand1 = 32'd2; i_Operand2 = 32'd2;
    #1 chk("flush_start_stall", o_Stall, 1'b0);
    @(negedge i_Clock);
    i_Start = 1'b0; i_Flush = 1'b0;
    chk("flush_start_busy", o_Busy, 1'b0);

    // Reset in the middle of a multiply, with a start also pulsed.
    i_Start = 1'b1; i_Op = 3'd0; i_Operand1 = 32'd5; i_Operand2 = 32'd5;
    @(negedge i_Clock);
    i_Start = 1'b0;
    repeat (4) @(negedge i_Clock);
    i_Start = 1'b1; i_Reset = 1'b1;
    #1 chk("rst_mid_stall", o_Stall, 1'b0);
    @(negedge i_Clock);
    chk("rst_mid_busy", o_Busy, 1'b0);
    chk("rst_mid_done", o_Done, 1'b0);
    chk("rst_mid_result", o_Result, 32'd0);
    chk("rst_mid_stall2", o_Stall, 1'b0);
    i_Reset = 1'b0; i_Start = 1'b0;
    repeat (40) @(negedge i_Clock);
    chk("rst_mid_quiet", o_Busy, 1'b0);

    for (int n = 0; n < 30; n++) run(3'($urandom), pick(), pick(), 0, 0);

    repeat (3) @(negedge i_Clock);
    chk("scoreboard_empty", scb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
